dqsw_training_ctrl: RTL and testbench

DQSW_TRAINING_CTRL -- requirements
Module: dqsw_training_ctrl

---
 rtl/dqsw_training_pkg.sv | 33 +++
 rtl/dqsw_training_ctrl_if.sv | 32 +++
 rtl/dqsw_sample_accum.sv | 33 +++
 rtl/dqsw_training_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dqsw_training_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dqsw_training_pkg.sv
// Shared types and constants for the DQS write-leveling training controller.
package dqsw_training_pkg;

    localparam int unsigned TAP_W = 8;
    localparam int unsigned ACC_W = 4;

    localparam logic       DIR_INC  = 1'b1;
    localparam logic [1:0] TX_PULSE = 2'b01;
    localparam logic [1:0] OE_PULSE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_PULSE  = 4'd2,
        ST_SETTLE = 4'd3,
        ST_SAMPLE = 4'd4,
        ST_DECIDE = 4'd5,
        ST_MOVE   = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } state_e;

    typedef enum logic {
        PH_SEEK0 = 1'b0,
        PH_SEEK1 = 1'b1
    } phase_e;

    // Strict majority: a tie between ones and zeros resolves to 0.
    function automatic logic majority_vote(input logic [ACC_W-1:0] ones, input int unsigned total);
        return (32'(ones) * 32'd2) > total;
    endfunction

endpackage

// File: rtl/dqsw_training_ctrl_if.sv
// Controller <-> IOD bundle: DQS pulse drive, write-leveling feedback and delay-line control.
interface dqsw_training_ctrl_if;

    logic [1:0] tx_data;
    logic [1:0] oe_data;
    logic [1:0] rx_data;
    logic       dl_load;
    logic       dl_move;
    logic       dl_direction;
    logic       dl_out_of_range;

    modport master (
        output tx_data,
        output oe_data,
        output dl_load,
        output dl_move,
        output dl_direction,
        input  rx_data,
        input  dl_out_of_range
    );

    modport slave (
        input  tx_data,
        input  oe_data,
        input  dl_load,
        input  dl_move,
        input  dl_direction,
        output rx_data,
        output dl_out_of_range
    );

endinterface

// File: rtl/dqsw_sample_accum.sv
// Per-tap pulse counter and ones accumulator with majority decision.
module dqsw_sample_accum
    import dqsw_training_pkg::*;
#(
    parameter int unsigned SAMPLE_COUNT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_sample,
    input  logic i_bit,
    output logic o_last_c,
    output logic o_result_c
);

    logic [ACC_W-1:0] r_pulse_cnt;
    logic [ACC_W-1:0] r_ones;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_pulse_cnt <= '0;
            r_ones      <= '0;
        end else if (i_sample) begin
            r_pulse_cnt <= r_pulse_cnt + ACC_W'(1);
            r_ones      <= r_ones + ACC_W'(i_bit);
        end
    end

    // High while the sample being taken is the last one for this tap.
    assign o_last_c   = (r_pulse_cnt == ACC_W'(SAMPLE_COUNT - 1));
    assign o_result_c = majority_vote(r_ones, SAMPLE_COUNT);

endmodule

// File: rtl/dqsw_training_ctrl.sv
// DQS write-leveling trainer: sweeps the IOD delay line until feedback goes 0 -> 1.
module dqsw_training_ctrl
    import dqsw_training_pkg::*;
#(
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_COUNT  = 4
) (
    input  logic                 i_fab_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_fail,
    output logic [TAP_W-1:0]     o_tap_count,
    dqsw_training_ctrl_if.master iod
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e              r_state, w_state_nxt;
    phase_e              r_phase, w_phase_nxt;
    logic [SETTLE_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [TAP_W-1:0]    r_tap, w_tap_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_fail, w_fail_nxt;
    logic [1:0]          r_tx_data, w_tx_data_nxt;
    logic [1:0]          r_oe_data, w_oe_data_nxt;
    logic                r_dl_load, w_dl_load_nxt;
    logic                r_dl_move, w_dl_move_nxt;
    logic                r_dl_dir, w_dl_dir_nxt;
    logic                w_acc_clear;
    logic                w_acc_sample;
    logic                w_acc_last;
    logic                w_acc_result;
    logic                w_unused_rx;

    assign w_unused_rx = iod.rx_data[1];

    dqsw_sample_accum #(
        .SAMPLE_COUNT (SAMPLE_COUNT)
    ) u_accum (
        .i_clk      (i_fab_clk),
        .i_reset    (i_reset),
        .i_clear    (w_acc_clear),
        .i_sample   (w_acc_sample),
        .i_bit      (iod.rx_data[0]),
        .o_last_c   (w_acc_last),
        .o_result_c (w_acc_result)
    );

    // State and registered outputs.
    always_ff @(posedge i_fab_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_SEEK0;
            r_settle_cnt <= '0;
            r_tap        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_tx_data    <= 2'b00;
            r_oe_data    <= 2'b00;
            r_dl_load    <= 1'b0;
            r_dl_move    <= 1'b0;
            r_dl_dir     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_tap        <= w_tap_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_oe_data    <= w_oe_data_nxt;
            r_dl_load    <= w_dl_load_nxt;
            r_dl_move    <= w_dl_move_nxt;
            r_dl_dir     <= w_dl_dir_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_settle_cnt_nxt = r_settle_cnt;
        w_tap_nxt        = r_tap;
        w_done_nxt       = r_done;
        w_fail_nxt       = r_fail;
        w_dl_move_nxt    = 1'b0;
        w_acc_clear      = 1'b0;
        w_acc_sample     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_phase_nxt = PH_SEEK0;
                    w_done_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_tap_nxt   = '0;
                    w_acc_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                w_state_nxt      = ST_SETTLE;
                w_settle_cnt_nxt = '0;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                w_acc_sample = 1'b1;
                w_state_nxt  = w_acc_last ? ST_DECIDE : ST_PULSE;
            end
            ST_DECIDE: begin
                w_acc_clear = 1'b1;
                if ((r_phase == PH_SEEK1) && w_acc_result) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    if ((r_phase == PH_SEEK0) && !w_acc_result) begin
                        w_phase_nxt = PH_SEEK1;
                    end
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // Saturation is only consulted here; a failing sweep issues no move.
                if ((r_tap == TAP_W'(MAX_TAPS - 1)) || iod.dl_out_of_range) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = ST_PULSE;
                    w_dl_move_nxt = 1'b1;
                    w_tap_nxt     = r_tap + TAP_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE) &&
                        (w_state_nxt != ST_FAIL);
        w_dl_load_nxt = (w_state_nxt == ST_LOAD);
        w_tx_data_nxt = (w_state_nxt == ST_PULSE) ? TX_PULSE : 2'b00;
        w_oe_data_nxt = (w_state_nxt == ST_PULSE) ? OE_PULSE : 2'b00;
        w_dl_dir_nxt  = w_dl_move_nxt ? DIR_INC : ~DIR_INC;
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_fail           = r_fail;
    assign o_tap_count      = r_tap;
    assign iod.tx_data      = r_tx_data;
    assign iod.oe_data      = r_oe_data;
    assign iod.dl_load      = r_dl_load;
    assign iod.dl_move      = r_dl_move;
    assign iod.dl_direction = r_dl_dir;

endmodule

// File: tb/tb_dqsw_training_ctrl.sv
// Bench for dqsw_training_ctrl: DRAM feedback model driven per tap/pulse, outcome from a sweep model.
module tb_dqsw_training_ctrl;

    localparam int unsigned MAX_TAPS     = 128;
    localparam int unsigned SAMPLE_COUNT = 4;
    localparam int          RUN_BOUND    = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] tap;

    dqsw_training_ctrl_if iod_if ();

    dqsw_training_ctrl #(
        .MAX_TAPS      (MAX_TAPS),
        .SETTLE_CYCLES (8),
        .SAMPLE_COUNT  (SAMPLE_COUNT)
    ) dut (
        .i_fab_clk   (clk),
        .i_reset     (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_fail      (fail),
        .o_tap_count (tap),
        .iod         (iod_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // DRAM model: number of ones returned among the pulses at each tap; saturation tap.
    int ones_cnt [MAX_TAPS];
    int oor_tap;

    // Bench view of the sweep, rebuilt from observed LOAD/MOVE/TX pulses.
    int m_tap, m_idx, n_moves, n_loads, n_pin_err;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic b;
        @(posedge clk);
        @(negedge clk);
        if (iod_if.dl_load) begin
            n_loads++;
            m_tap = 0;
            m_idx = 0;
        end
        if (iod_if.dl_move) begin
            n_moves++;
            if (m_tap < int'(MAX_TAPS) - 1) m_tap++;
            m_idx = 0;
        end
        if (iod_if.dl_direction !== iod_if.dl_move) n_pin_err++;
        if ((iod_if.tx_data == 2'b01) !== (iod_if.oe_data == 2'b11)) n_pin_err++;
        if ((iod_if.tx_data !== 2'b00) && (iod_if.tx_data !== 2'b01)) n_pin_err++;
        if (iod_if.tx_data == 2'b01) begin
            b = (m_idx < ones_cnt[m_tap]);
            m_idx++;
            iod_if.rx_data = {1'($urandom), b};
        end
        iod_if.dl_out_of_range = (oor_tap >= 0) && (m_tap >= oor_tap);
    endtask

    // Sweep outcome from the rules: find a 0, then the first 1 after it.
    function automatic void ref_model(output int e_done, output int e_fail,
                                      output int e_tap, output int e_moves);
        int  t;
        bit  seek1;
        bit  hi;
        t = 0; seek1 = 0;
        e_done = 0; e_fail = 0; e_tap = 0; e_moves = 0;
        for (int g = 0; g < int'(MAX_TAPS); g++) begin
            hi = (ones_cnt[t] * 2) > int'(SAMPLE_COUNT);
            if (seek1 && hi) begin
                e_done = 1; e_tap = t; return;
            end
            if (!seek1 && !hi) seek1 = 1;
            if ((t == int'(MAX_TAPS) - 1) || ((oor_tap >= 0) && (t >= oor_tap))) begin
                e_fail = 1; e_tap = t; return;
            end
            t++;
            e_moves++;
        end
    endfunction

    task automatic run_case(input string name, input bit inject_start, input int e_done,
                            input int e_fail, input int e_tap, input int e_moves);
        int cyc;
        n_moves = 0; n_loads = 0; n_pin_err = 0; m_tap = 0; m_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "/busy_on"}, int'(busy), 1);
        check({name, "/load"}, int'(iod_if.dl_load), 1);
        check({name, "/flags_clr"}, int'({done, fail}), 0);
        check({name, "/tap_clr"}, int'(tap), 0);
        cyc = 0;
        while (!(done || fail) && (cyc < RUN_BOUND)) begin
            start = inject_start && (cyc == 100);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({name, "/finished"}, int'(done | fail), 1);
        check({name, "/done"}, int'(done), e_done);
        check({name, "/fail"}, int'(fail), e_fail);
        check({name, "/tap"}, int'(tap), e_tap);
        check({name, "/moves"}, n_moves, e_moves);
        check({name, "/loads"}, n_loads, 1);
        check({name, "/pins"}, n_pin_err, 0);
        check({name, "/busy_off"}, int'(busy), 0);
        tick();
        check({name, "/sticky"}, int'({done, fail}), (e_done << 1) | e_fail);
        check({name, "/idle"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, e_done, e_fail, e_tap, e_moves;
        rst = 1'b1;
        start = 1'b0;
        iod_if.rx_data = 2'b00;
        iod_if.dl_out_of_range = 1'b0;
        oor_tap = -1;
        foreach (ones_cnt[t]) ones_cnt[t] = 0;
        repeat (3) tick();

        check("reset/busy", int'(busy), 0);
        check("reset/done", int'(done), 0);
        check("reset/fail", int'(fail), 0);
        check("reset/tap", int'(tap), 0);
        check("reset/tx", int'(iod_if.tx_data), 0);
        check("reset/oe", int'(iod_if.oe_data), 0);
        check("reset/dl_ctrl", int'({iod_if.dl_load, iod_if.dl_move, iod_if.dl_direction}), 0);
        rst = 1'b0;
        tick();
        check("idle/busy", int'(busy), 0);

        // Edge at tap 5.
        foreach (ones_cnt[t]) ones_cnt[t] = (t >= 5) ? 4 : 0;
        run_case("edge5", 1'b0, 1, 0, 5, 5);

        // Ones at 0..2, zeros 3..9, ones again from 10.
        foreach (ones_cnt[t]) ones_cnt[t] = ((t <= 2) || (t >= 10)) ? 4 : 0;
        run_case("edge10", 1'b0, 1, 0, 10, 10);

        // Never a one: sweep ends at the last tap.
        foreach (ones_cnt[t]) ones_cnt[t] = 0;
        run_case("all0", 1'b0, 0, 1, 127, 127);

        // Delay line saturates at tap 20.
        oor_tap = 20;
        run_case("oor20", 1'b0, 0, 1, 20, 20);
        oor_tap = -1;

        // Majority vote: 2-of-4 is a tie (0), 3-of-4 is a one.
        foreach (ones_cnt[t]) ones_cnt[t] = 0;
        ones_cnt[3] = 2;
        ones_cnt[4] = 3;
        run_case("vote", 1'b0, 1, 0, 4, 4);

        // Reset mid-sweep at the third move, then restart with START pulsed while busy.
        foreach (ones_cnt[t]) ones_cnt[t] = 0;
        n_moves = 0; n_loads = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while ((n_moves < 3) && (cyc < 2000)) begin
            tick();
            cyc++;
        end
        check("rst/third_move", n_moves, 3);
        rst = 1'b1;
        tick();
        check("rst/dl_pulses", int'({iod_if.dl_load, iod_if.dl_move}), 0);
        check("rst/busy", int'(busy), 0);
        check("rst/tap", int'(tap), 0);
        rst = 1'b0;
        tick();
        check("rst/dl_pulses_after", int'({iod_if.dl_load, iod_if.dl_move}), 0);
        check("rst/no_more_moves", n_moves, 3);
        check("rst/loads", n_loads, 1);
        foreach (ones_cnt[t]) ones_cnt[t] = (t >= 5) ? 4 : 0;
        run_case("restart", 1'b1, 1, 0, 5, 5);

        // Randomized DRAM responses checked against the sweep model.
        for (int k = 0; k < 6; k++) begin
            foreach (ones_cnt[t]) ones_cnt[t] = int'($urandom_range(0, 4));
            oor_tap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
            ref_model(e_done, e_fail, e_tap, e_moves);
            run_case($sformatf("rand%0d", k), 1'b0, e_done, e_fail, e_tap, e_moves);
        end

        // Long random sweep with no majority one anywhere.
        oor_tap = -1;
        foreach (ones_cnt[t]) ones_cnt[t] = int'($urandom_range(0, 2));
        ref_model(e_done, e_fail, e_tap, e_moves);
        run_case("rand_low", 1'b0, e_done, e_fail, e_tap, e_moves);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
